tinker_muldiv: RTL and testbench

Multi-cycle integer multiply/divide unit with a parametrised operand width. It replaces the single-cycle combinational mul/div path in the core's ALU. Adds signed division, remainder, a defined divide-by-zero result, a destination tag, and valid/ready handshakes so the core FSM can stall on it.

---
 rtl/tinker_muldiv.sv | 144 ++++++++++++++
 tb/tb_tinker_muldiv.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tinker_muldiv.sv
// Multi-cycle integer multiply / divide unit: shift-add multiply, restoring
// divide (unsigned and signed), unsigned remainder, with valid/ready handshakes.
module tinker_muldiv #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_DIVS = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // |most-negative| wraps to itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg2c(v) : v;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [1:0]       op_r;
  logic             sign_r;
  logic             accept;
  logic             b_zero;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] fixup_val;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign b_zero    = (op != OP_MUL) && (b == '0);

  // x holds the multiplier (MUL) or the dividend shifting into the quotient (DIV);
  // acc holds the product or the partial remainder.
  assign trial   = {acc, x[WIDTH-1]};
  assign diff    = trial - {1'b0, y};
  assign mul_sum = acc + y;

  always_comb begin
    fixup_val = acc;
    case (op_r)
      OP_MUL:  fixup_val = acc;
      OP_DIVU: fixup_val = x;
      OP_DIVS: fixup_val = sign_r ? neg2c(x) : x;
      default: fixup_val = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Divide-by-zero detours through FIXUP so its result lands one edge after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = b_zero ? FIXUP : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)                          cnt <= '0;
    else if (accept)                     cnt <= CNT_W'(WIDTH);
    else if (state == RUN && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_r <= op;
      acc  <= '0;
      if (op == OP_MUL) begin
        x      <= b;
        y      <= a;
        sign_r <= 1'b0;
      end else if (op == OP_DIVS) begin
        x      <= abs_val(a);
        y      <= abs_val(b);
        sign_r <= a[WIDTH-1] ^ b[WIDTH-1];
      end else begin
        x      <= a;
        y      <= b;
        sign_r <= 1'b0;
      end
    end else if (state == RUN) begin
      if (op_r == OP_MUL) begin
        if (x[0]) acc <= mul_sum;
        x <= x >> 1;
        y <= y << 1;
      end else if (!diff[WIDTH]) begin
        acc <= diff[WIDTH-1:0];
        x   <= {x[WIDTH-2:0], 1'b1};
      end else begin
        acc <= trial[WIDTH-1:0];
        x   <= {x[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      result      <= '0;
      tag_out     <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      tag_out     <= tag_in;
      div_by_zero <= b_zero;
      if (b_zero) result <= (op == OP_REMU) ? a : '1;
    end else if (state == FIXUP && !div_by_zero) begin
      result <= fixup_val;
    end
  end

endmodule

// File: tb/tb_tinker_muldiv.sv
// Scoreboard bench for tinker_muldiv at WIDTH=64 and WIDTH=8.
module tb_tinker_muldiv;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv64, iv8, ordy;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic [4:0]  tag;
  logic        ir64, ov64, dz64, ir8, ov8, dz8;
  logic [63:0] res64;
  logic [7:0]  res8;
  logic [4:0]  to64, to8;

  exp_t q64[$];
  exp_t q8[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  tinker_muldiv #(.WIDTH(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .op(op),
    .a(a), .b(b), .tag_in(tag), .out_valid(ov64), .out_ready(ordy),
    .result(res64), .tag_out(to64), .div_by_zero(dz64)
  );

  tinker_muldiv #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .tag_in(tag), .out_valid(ov8), .out_ready(ordy),
    .result(res8), .tag_out(to8), .div_by_zero(dz8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitors: compare each result the first cycle it is presented.
  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov64 && !seen) begin
        seen = 1;
        if (q64.size() == 0) chk("w64 unexpected result", 64'd1, 64'd0);
        else begin
          e = q64.pop_front();
          chk("w64 result", res64, e.res);
          chk("w64 tag_out", {59'd0, to64}, {59'd0, e.tag});
          chk("w64 div_by_zero", {63'd0, dz64}, {63'd0, e.dz});
        end
      end else if (!ov64) seen = 0;
    end
  end

  initial begin
    bit   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov8 && !seen) begin
        seen = 1;
        if (q8.size() == 0) chk("w8 unexpected result", 64'd1, 64'd0);
        else begin
          e = q8.pop_front();
          chk("w8 result", {56'd0, res8}, e.res);
          chk("w8 tag_out", {59'd0, to8}, {59'd0, e.tag});
          chk("w8 div_by_zero", {63'd0, dz8}, {63'd0, e.dz});
        end
      end else if (!ov8) seen = 0;
    end
  end

  task automatic issue(input bit w8, input logic [1:0] o, input logic [63:0] aa,
                       input logic [63:0] bb, input logic [4:0] t, input logic [63:0] er,
                       input logic edz, input int elat, input int hold);
    exp_t        e;
    int          lat;
    logic [63:0] r0;
    logic [4:0]  t0;
    @(negedge clk);
    op = o; a = aa; b = bb; tag = t; ordy = (hold == 0);
    e.res = er; e.tag = t; e.dz = edz;
    if (w8) begin q8.push_back(e); iv8 = 1'b1; end
    else    begin q64.push_back(e); iv64 = 1'b1; end
    chk("in_ready idle", {63'd0, w8 ? ir8 : ir64}, 64'd1);
    @(negedge clk);
    iv8 = 1'b0; iv64 = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    op = 2'($urandom); tag = 5'($urandom);
    chk("in_ready busy", {63'd0, w8 ? ir8 : ir64}, 64'd0);
    lat = 0;
    while (!(w8 ? ov8 : ov64) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    if (hold > 0) begin
      r0 = w8 ? {56'd0, res8} : res64;
      t0 = w8 ? to8 : to64;
      repeat (hold) begin
        @(negedge clk);
        chk("hold result", w8 ? {56'd0, res8} : res64, r0);
        chk("hold tag_out", {59'd0, w8 ? to8 : to64}, {59'd0, t0});
        chk("hold in_ready", {63'd0, w8 ? ir8 : ir64}, 64'd0);
        chk("hold out_valid", {63'd0, w8 ? ov8 : ov64}, 64'd1);
      end
      ordy = 1'b1;
    end
    @(negedge clk);
    chk("out_valid drop", {63'd0, w8 ? ov8 : ov64}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit stray;
    reset = 1'b0; iv64 = 1'b0; iv8 = 1'b0; ordy = 1'b1;
    op = 2'd0; a = '0; b = '0; tag = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", {63'd0, ir64}, 64'd1);
    chk("reset out_valid", {63'd0, ov64}, 64'd0);
    chk("reset result", res64, 64'd0);
    chk("reset tag_out", {59'd0, to64}, 64'd0);
    chk("reset div_by_zero", {63'd0, dz64}, 64'd0);
    chk("reset w8 in_ready", {63'd0, ir8}, 64'd1);
    reset = 1'b1;

    issue(0, 2'd0, 64'd3, 64'd5, 5'd7, 64'd15, 1'b0, 65, 0);
    issue(0, 2'd0, 64'h8000_0000_0000_0000, 64'd2, 5'd1, 64'd0, 1'b0, 65, 0);
    issue(0, 2'd0, '1, '1, 5'd2, 64'd1, 1'b0, 65, 0);
    issue(0, 2'd1, 64'd100, 64'd7, 5'd3, 64'd14, 1'b0, 65, 0);
    issue(0, 2'd3, 64'd100, 64'd7, 5'd4, 64'd2, 1'b0, 65, 0);
    issue(0, 2'd2, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd5, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 65, 0);
    issue(0, 2'd2, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd6, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 65, 0);
    issue(0, 2'd2, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd8, 64'd14, 1'b0, 65, 0);
    issue(0, 2'd2, 64'h8000_0000_0000_0000, '1, 5'd9, 64'h8000_0000_0000_0000, 1'b0, 65, 0);
    issue(0, 2'd1, 64'd9, 64'd0, 5'd10, '1, 1'b1, 1, 0);
    issue(0, 2'd3, 64'd9, 64'd0, 5'd11, 64'd9, 1'b1, 1, 0);
    issue(0, 2'd2, 64'd5, 64'd0, 5'd12, '1, 1'b1, 1, 0);
    issue(0, 2'd1, 64'd100, 64'd7, 5'd13, 64'd14, 1'b0, 65, 10);

    // Abort mid-RUN: reset sampled while the counter reads 30.
    @(negedge clk);
    op = 2'd0; a = 64'd5; b = 64'd6; tag = 5'd17; ordy = 1'b1; iv64 = 1'b1;
    @(negedge clk);
    iv64 = 1'b0;
    repeat (34) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort out_valid", {63'd0, ov64}, 64'd0);
    chk("abort in_ready", {63'd0, ir64}, 64'd1);
    chk("abort result", res64, 64'd0);
    chk("abort tag_out", {59'd0, to64}, 64'd0);
    stray = 0;
    repeat (80) begin
      @(negedge clk);
      if (ov64) stray = 1;
    end
    chk("abort no result", {63'd0, stray}, 64'd0);

    issue(1, 2'd1, 64'd100, 64'd7, 5'd20, 64'd14, 1'b0, 9, 0);
    issue(1, 2'd2, 64'h9C, 64'd7, 5'd21, 64'hF2, 1'b0, 9, 0);
    issue(1, 2'd3, 64'd100, 64'd7, 5'd22, 64'd2, 1'b0, 9, 0);
    issue(1, 2'd0, 64'hFF, 64'hFF, 5'd23, 64'h01, 1'b0, 9, 0);
    issue(1, 2'd2, 64'h80, 64'hFF, 5'd24, 64'h80, 1'b0, 9, 0);
    issue(1, 2'd1, 64'd9, 64'd0, 5'd25, 64'hFF, 1'b1, 1, 3);

    repeat (5) @(negedge clk);
    chk("w64 queue drained", 64'(q64.size()), 64'd0);
    chk("w8 queue drained", 64'(q8.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
